// File: rtl/fetch_stream_if.sv
// fetch_stream bundle types and port interface.
// Ports: fetch_req/fetch_rsp (fetch port), out_valid/out_inst/out_pc/out_ready (decode).
package fetch_stream_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
    } inst_fetch_req_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        done;
    } inst_fetch_rsp_t;

endpackage

interface fetch_stream_if;
    import fetch_stream_pkg::*;

    inst_fetch_req_t fetch_req;
    inst_fetch_rsp_t fetch_rsp;
    logic            out_valid;
    logic [31:0]     out_inst;
    logic [31:0]     out_pc;
    logic            out_ready;

    modport master (
        output fetch_req,
        input  fetch_rsp,
        output out_valid,
        output out_inst,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  fetch_req,
        output fetch_rsp,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_stream.sv
// Sequential instruction fetch sequencer with a small {inst, pc} output FIFO.
// Ports: clk, rst (async low), en, redirect_valid/redirect_pc, fs (fetch + decode), buf_count.
module fetch_stream
    import fetch_stream_pkg::*;
#(
    parameter int unsigned buf_depth = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    fetch_stream_if.master            fs,
    output logic [$clog2(buf_depth):0] buf_count
);

    localparam int unsigned PW = $clog2(buf_depth);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(buf_depth);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STALL,
        FLUSH
    } state_t;

    state_t        state, state_n;
    logic [31:0]   cur_pc, cur_pc_n;
    logic [31:0]   tgt_pc, tgt_pc_n;
    logic [31:0]   mem_inst [buf_depth];
    logic [31:0]   mem_pc   [buf_depth];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_n;
    logic          push, pop, done;
    logic [31:0]   rpc;

    assign rpc  = redirect_pc & ~32'h3;
    assign done = fs.fetch_rsp.done;

    assign fs.out_valid = (count != '0);
    assign fs.out_inst  = mem_inst[head];
    assign fs.out_pc    = mem_pc[head];
    assign buf_count    = count;

    // A redirect wipes the FIFO, so a pop in that cycle must not count.
    assign pop = fs.out_valid & fs.out_ready & ~redirect_valid;

    always_comb begin
        state_n            = state;
        cur_pc_n           = cur_pc;
        tgt_pc_n           = tgt_pc;
        push               = 1'b0;
        fs.fetch_req.pc    = cur_pc;
        fs.fetch_req.valid = 1'b0;
        count_n = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        unique case (state)
            IDLE: begin
                if (redirect_valid) begin
                    cur_pc_n = rpc;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                // done may still be high from the previous request here.
                fs.fetch_req.valid = 1'b1;
                if (redirect_valid) begin
                    tgt_pc_n = rpc;
                    state_n  = FLUSH;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                fs.fetch_req.valid = 1'b1;
                if (redirect_valid) begin
                    if (done) begin
                        cur_pc_n = rpc;
                        state_n  = ISSUE;
                    end else begin
                        tgt_pc_n = rpc;
                        state_n  = FLUSH;
                    end
                end else if (done) begin
                    push     = 1'b1;
                    cur_pc_n = cur_pc + 32'd4;
                    count_n  = count + {{(CW-1){1'b0}}, 1'b1}
                                     - {{(CW-1){1'b0}}, pop};
                    state_n  = (count_n < DEPTH_C) ? ISSUE : STALL;
                end
            end
            STALL: begin
                if (redirect_valid) begin
                    cur_pc_n = rpc;
                    state_n  = ISSUE;
                end else if (count < DEPTH_C) begin
                    state_n = ISSUE;
                end
            end
            FLUSH: begin
                // The old request cannot be cancelled; hold it until done.
                fs.fetch_req.valid = 1'b1;
                if (done) begin
                    cur_pc_n = redirect_valid ? rpc : tgt_pc;
                    state_n  = ISSUE;
                end else if (redirect_valid) begin
                    tgt_pc_n = rpc;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cur_pc <= '0;
            tgt_pc <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            for (int i = 0; i < int'(buf_depth); i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else if (en) begin
            state  <= state_n;
            cur_pc <= cur_pc_n;
            tgt_pc <= tgt_pc_n;
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    mem_inst[tail] <= fs.fetch_rsp.inst;
                    mem_pc[tail]   <= cur_pc;
                    tail           <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count_n;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stream.sv
// Scoreboard bench for fetch_stream: directed stimulus, fake fetch port, output monitor.
// Ports: none.
module tb_fetch_stream;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  buf_count;

    fetch_stream_if bus ();

    fetch_stream #(.buf_depth(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fs             (bus),
        .buf_count      (buf_count)
    );

    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          age   = 0;
    bit          auto_rsp = 1;
    int          lat      = 1;
    logic        man_done = 0;
    logic [31:0] rsp_inst = 32'h13;
    bit          trk   = 0;
    int          maxc  = 0;
    int          req_starts = 0;
    logic [31:0] last_pc = '0;
    logic        prev_v  = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_req(input string name, input logic [31:0] pc,
                           input logic v);
        chk({name, "_pc"}, bus.fetch_req.pc, pc);
        chk({name, "_v"}, {31'b0, bus.fetch_req.valid}, {31'b0, v});
    endtask

    // Fake fetch port: done after lat cycles of a request, or manual.
    always @(posedge clk) begin
        if (!rst) age = 0;
        else if (en) begin
            if (!bus.fetch_req.valid || bus.fetch_rsp.done) age = 0;
            else age++;
        end
    end

    always begin
        @(negedge clk);
        #1;
        bus.fetch_rsp.inst = rsp_inst;
        bus.fetch_rsp.done = auto_rsp ? (bus.fetch_req.valid && age >= lat)
                                      : man_done;
        if (bus.fetch_req.valid && !prev_v) begin
            req_starts++;
            last_pc = bus.fetch_req.pc;
        end
        prev_v = bus.fetch_req.valid;
        if (trk && int'(buf_count) > maxc) maxc = int'(buf_count);
    end

    always begin
        @(negedge clk);
        #2;
        if (rst && en && bus.out_valid && bus.out_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got pc %h inst %h expected none",
                         bus.out_pc, bus.out_inst);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc", bus.out_pc, e.pc);
                chk("sb_inst", bus.out_inst, e.inst);
            end
        end
    end

    initial begin
        rst = 0;
        en = 1;
        redirect_valid = 0;
        redirect_pc = '0;
        bus.out_ready = 0;
        cyc();
        chk_req("rst_req", 32'h0, 1'b0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_out_inst", bus.out_inst, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_count", {29'b0, buf_count}, 32'h0);
        rst = 1;
        cyc();

        bus.out_ready = 1;
        for (int i = 0; i < 4; i++)
            sb.push_back('{pc: 32'h100 + 32'(4 * i), inst: 32'h13});
        trk = 1;
        redirect_valid = 1;
        redirect_pc = 32'h100;
        cyc();
        redirect_valid = 0;
        chk_req("t1_first", 32'h100, 1'b1);
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (sb.size() == 0) break;
        end
        chk("t1_drain", sb.size(), 32'h0);
        trk = 0;
        chk("t1_max_count", maxc, 32'h1);

        bus.out_ready = 0;
        rsp_inst = 32'h0010_0093;
        redirect_valid = 1;
        redirect_pc = 32'h0;
        cyc();
        redirect_valid = 0;
        chk_req("t2_first", 32'h0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if (buf_count == 3'd4) break;
            cyc();
        end
        chk("t2_full", {29'b0, buf_count}, 32'h4);
        chk_req("t2_stall", 32'h10, 1'b0);
        chk("t2_head_pc", bus.out_pc, 32'h0);
        cyc();
        cyc();
        chk("t2_stall_hold", {31'b0, bus.fetch_req.valid}, 32'h0);
        sb.push_back('{pc: 32'h0, inst: 32'h0010_0093});
        req_starts = 0;
        bus.out_ready = 1;
        cyc();
        bus.out_ready = 0;
        repeat (10) cyc();
        chk("t2_one_req", req_starts, 32'h1);
        chk("t2_req_pc", last_pc, 32'h10);
        chk("t2_refull", {29'b0, buf_count}, 32'h4);
        chk("t2_restall", {31'b0, bus.fetch_req.valid}, 32'h0);

        rsp_inst = 32'h1111_1111;
        redirect_valid = 1;
        redirect_pc = 32'h3C;
        cyc();
        redirect_valid = 0;
        cyc();
        cyc();
        auto_rsp = 0;
        man_done = 0;
        chk("t3_one_entry", {29'b0, buf_count}, 32'h1);
        cyc();
        chk_req("t3_wait40", 32'h40, 1'b1);
        redirect_valid = 1;
        redirect_pc = 32'h200;
        rsp_inst = 32'hDEAD_BEEF;
        cyc();
        redirect_valid = 0;
        chk("t3_flushed", {29'b0, buf_count}, 32'h0);
        chk("t3_no_valid", {31'b0, bus.out_valid}, 32'h0);
        chk_req("t3_hold", 32'h40, 1'b1);
        cyc();
        cyc();
        man_done = 1;
        cyc();
        man_done = 0;
        chk_req("t3_new", 32'h200, 1'b1);
        chk("t3_discard", {29'b0, buf_count}, 32'h0);
        cyc();
        rsp_inst = 32'h2222_2222;
        bus.out_ready = 1;
        man_done = 1;
        sb.push_back('{pc: 32'h200, inst: 32'h2222_2222});
        cyc();
        man_done = 0;

        cyc();
        redirect_valid = 1;
        redirect_pc = 32'h300;
        cyc();
        redirect_pc = 32'h400;
        cyc();
        redirect_valid = 0;
        chk_req("t4_hold", 32'h204, 1'b1);
        cyc();
        man_done = 1;
        cyc();
        man_done = 0;
        chk_req("t4_last_wins", 32'h400, 1'b1);

        cyc();
        man_done = 1;
        redirect_valid = 1;
        redirect_pc = 32'hFFFF_FFFE;
        bus.out_ready = 0;
        cyc();
        redirect_valid = 0;
        man_done = 0;
        chk_req("t5_first", 32'hFFFF_FFFC, 1'b1);
        chk("t5_same_cycle", {29'b0, buf_count}, 32'h0);
        rsp_inst = 32'h3333_3333;
        cyc();
        man_done = 1;
        cyc();
        man_done = 0;
        chk_req("t5_wrap", 32'h0, 1'b1);
        chk("t5_head_pc", bus.out_pc, 32'hFFFF_FFFC);
        sb.push_back('{pc: 32'hFFFF_FFFC, inst: 32'h3333_3333});

        cyc();
        en = 0;
        man_done = 1;
        bus.out_ready = 1;
        cyc();
        man_done = 0;
        cyc();
        man_done = 1;
        redirect_valid = 1;
        redirect_pc = 32'h500;
        cyc();
        man_done = 0;
        redirect_valid = 0;
        cyc();
        man_done = 1;
        cyc();
        chk_req("t6_hold", 32'h0, 1'b1);
        chk("t6_count", {29'b0, buf_count}, 32'h1);
        chk("t6_out_pc", bus.out_pc, 32'hFFFF_FFFC);
        chk("t6_out_inst", bus.out_inst, 32'h3333_3333);
        en = 1;
        man_done = 1;
        rsp_inst = 32'h4444_4444;
        sb.push_back('{pc: 32'h0, inst: 32'h4444_4444});
        cyc();
        man_done = 0;
        chk("t6_pushpop", {29'b0, buf_count}, 32'h1);
        chk("t6_new_head", bus.out_pc, 32'h0);
        chk_req("t6_next", 32'h4, 1'b1);
        cyc();
        bus.out_ready = 0;
        repeat (4) cyc();
        chk("end_sb_empty", sb.size(), 32'h0);
        chk("end_count", {29'b0, buf_count}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stream.md
# fetch_stream

Single-path instruction fetch sequencer that sits directly upstream of `fetch_queue`: it owns one fetch port, generates sequential PCs, and holds a `core::inst_fetch_req_t` until the matching `core::inst_fetch_rsp_t` completes. Returned instructions are buffered, with their PCs, in a small FIFO that decode drains through a valid/ready handshake. A redirect flushes the stream and restarts it at a new PC. Any in-flight request is completed and its result discarded, because `fetch_queue` cannot cancel.

## Interface
- `buf_depth`, 4: instruction FIFO entries; power of two, ≥2
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  stall; when 0 all state holds and outputs are unchanged
- `redirect_valid`  in  1  flush and (re)start the stream
- `redirect_pc`  in  32  new PC (`sys::addr_t`); bits [1:0] are ignored and stored as 0
- `fetch_req`  out  `core::inst_fetch_req_t`  {pc, valid} to a `fetch_queue` port
- `fetch_rsp`  in  `core::inst_fetch_rsp_t`  {inst, done} from the same port
- `out_valid`  out  1  FIFO head valid
- `out_inst`  out  32  head instruction (`rv32i::inst_t`)
- `out_pc`  out  32  head PC
- `out_ready`  in  1  decode accepts the head
- `buf_count`  out  $clog2(buf_depth)+1  FIFO occupancy

## Operation
- State machine states: IDLE, ISSUE, WAIT, STALL, FLUSH. Registers: `cur_pc`, `tgt_pc`, FIFO {inst, pc} × buf_depth, head/tail pointers, `count`.
- IDLE: `fetch_req.valid`=0. On redirect: `cur_pc`←redirect_pc, go to ISSUE.
- ISSUE: `fetch_req`={cur_pc,1}. `done` is ignored because it may be stale from the previous request. Always go to WAIT.
- WAIT: `fetch_req`={cur_pc,1}. On `done`=1, push {fetch_rsp.inst, cur_pc} and set `cur_pc`←cur_pc+4.
  - Go to ISSUE if next count < buf_depth.
  - Otherwise go to STALL.
- STALL: `fetch_req.valid`=0. Go to ISSUE when count < buf_depth.
- FLUSH: keeps holding the old request (`valid`=1, old `cur_pc`). On `done`, discard the data, set `cur_pc`←tgt_pc and go to ISSUE.
- Redirect handling:
  - In ISSUE or WAIT: `tgt_pc`←redirect_pc, go to FLUSH. If `done` arrives in that same WAIT cycle, the data is discarded and the next state is ISSUE at redirect_pc.
  - In FLUSH: overwrites `tgt_pc` (last redirect wins).
  - In STALL or IDLE: go directly to ISSUE at redirect_pc.
- Every redirect clears the FIFO (count←0, head=tail=0) in the same edge. Redirect has priority over pop and push.
- Pop: when `out_valid & out_ready & en` and no redirect, head advances and count decrements.
- Push and pop in the same cycle: count is unchanged.
- The space check counts the in-flight request. A request is issued only when count < buf_depth, so a push never overflows.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0. Pointers wrap modulo buf_depth.
- `out_valid` = (count≠0). `out_inst` and `out_pc` come from the head entry, registered storage, with no combinational path from `fetch_rsp`.

## Timing
- Reset: state=IDLE, `fetch_req`='0, `out_valid`=0, `out_inst`=0, `out_pc`=0, `buf_count`=0, all pointers and PCs 0.
- Reset is honoured in any state, including mid-request. After reset, no response for the abandoned request is accepted.
- `redirect_valid` at edge T (from IDLE/STALL) → `fetch_req.valid`=1 with the new PC from T+1.
- Minimum request lifetime is 2 cycles (ISSUE+WAIT).
- `done` sampled at edge T → entry visible on `out_*` from T+1 (if the FIFO was empty). The next request is presented from T+1.
- Peak throughput is 1 instruction per 2 cycles.
- With `en`=0, `redirect_valid`, `done` and `out_ready` are all ignored for that cycle.

## Test plan
- Reset, then redirect to 0x100, with `done` returned 1 cycle into WAIT and inst=0x00000013 each time; `out_ready`=1 → the out stream is PCs 0x100, 0x104, 0x108, 0x10C, one per 2 cycles, and `buf_count` never exceeds 1.
- `out_ready`=0, buf_depth=4, starting at 0x0 → 4 entries are captured, state goes to STALL with `fetch_req.valid`=0 and `buf_count`=4. Raising `out_ready` for 1 cycle → exactly one new request at PC 0x10.
- Redirect to 0x200 while in WAIT for 0x40, with `done` arriving 3 cycles later with inst 0xDEADBEEF → that data is never output, the FIFO is emptied at the redirect edge, and the next request has pc=0x200.
- Two redirects during FLUSH (0x300, then 0x400) → the first request after FLUSH has pc=0x400.
- Redirect to 0xFFFF_FFFE → the first request has pc=0xFFFF_FFFC and the second has pc=0x0000_0000.
- `en`=0 held 5 cycles while in WAIT, with `done` toggling → there is no state, FIFO or output change. Resuming with `en`=1 and `done`=1 captures the instruction.
